mdu_sequencer: RTL and testbench

- Iterative multiply/divide controller and HI/LO owner for the pipelined MIPS core.
- Accepts decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the execute stage.
- Runs a WIDTH-cycle shift-add multiply or restoring divide, then a sign fix-up cycle, then writes HI/LO.
- Asserts a stall to the hazard logic while busy.

---
 rtl/mdu_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair of the MIPS core.
// Optional feature macro: MDU_EARLY_TERM_EN (multiply ends once the remaining multiplier bits are zero).
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_valid,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic [WIDTH-1:0] md_rdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic [WIDTH-1:0]     quot_reg, quot_next;
    logic [WIDTH-1:0]     rem_reg, rem_next;
    logic [WIDTH-1:0]     dvsr_reg, dvsr_next;
    logic                 sign_reg, sign_next;
    logic                 rsign_reg, rsign_next;
    logic                 dz_reg, dz_next;
    logic                 is_div_reg, is_div_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;
    logic                 done_reg, done_next;

    logic                 op_signed;
    logic                 rs_neg;
    logic                 rt_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 cnt_last;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Even opcodes (MULT, DIV) are the signed forms.
    assign op_signed = ~md_op[0];
    assign rs_neg    = rs_val[WIDTH-1];
    assign rt_neg    = rt_val[WIDTH-1];
    assign a_mag     = (op_signed && rs_neg) ? -rs_val : rs_val;
    assign b_mag     = (op_signed && rt_neg) ? -rt_val : rt_val;

    assign cnt_last  = (cnt_reg == CNT_W'(WIDTH - 1));
    assign acc_step  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

`ifdef MDU_EARLY_TERM_EN
    assign mul_last  = cnt_last || (mplier_reg[WIDTH-1:1] == '0);
`else
    assign mul_last  = cnt_last;
`endif

    // Restoring step: a clear borrow bit means the divisor fits into the partial remainder.
    assign div_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, dvsr_reg};

    assign prod_fix  = sign_reg  ? -acc_reg  : acc_reg;
    assign quot_fix  = sign_reg  ? -quot_reg : quot_reg;
    assign rem_fix   = rsign_reg ? -rem_reg  : rem_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        quot_next   = quot_reg;
        rem_next    = rem_reg;
        dvsr_next   = dvsr_reg;
        sign_next   = sign_reg;
        rsign_next  = rsign_reg;
        dz_next     = dz_reg;
        is_div_next = is_div_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;

        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (md_valid) begin
                        case (md_op)
                            3'b000, 3'b001: begin
                                mcand_next  = {{WIDTH{1'b0}}, a_mag};
                                mplier_next = b_mag;
                                acc_next    = '0;
                                cnt_next    = '0;
                                sign_next   = op_signed & (rs_neg ^ rt_neg);
                                is_div_next = 1'b0;
                                state_next  = MUL;
                            end
                            3'b010, 3'b011: begin
                                quot_next   = a_mag;
                                rem_next    = '0;
                                dvsr_next   = b_mag;
                                cnt_next    = '0;
                                sign_next   = op_signed & (rs_neg ^ rt_neg);
                                rsign_next  = op_signed & rs_neg;
                                dz_next     = (rt_val == '0);
                                is_div_next = 1'b1;
                                state_next  = DIV;
                            end
                            3'b100:  hi_next = rs_val;
                            3'b101:  lo_next = rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc_next    = acc_step;
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = (cnt_reg == CNT_W'(WIDTH)) ? cnt_reg : cnt_reg + CNT_W'(1);
                    if (mul_last) begin
                        state_next = FIX;
                    end
                end
                DIV: begin
                    if (!div_trial[WIDTH]) begin
                        rem_next  = div_trial[WIDTH-1:0];
                        quot_next = {quot_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_next  = div_shift[WIDTH-1:0];
                        quot_next = {quot_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_next = (cnt_reg == CNT_W'(WIDTH)) ? cnt_reg : cnt_reg + CNT_W'(1);
                    if (cnt_last) begin
                        state_next = FIX;
                    end
                end
                FIX: begin
                    if (is_div_reg) begin
                        // A zero divisor leaves the raw all-ones quotient and |rs| remainder.
                        lo_next = dz_reg ? quot_reg : quot_fix;
                        hi_next = dz_reg ? rem_reg  : rem_fix;
                    end else begin
                        {hi_next, lo_next} = prod_fix;
                    end
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            quot_reg   <= '0;
            rem_reg    <= '0;
            dvsr_reg   <= '0;
            sign_reg   <= 1'b0;
            rsign_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            is_div_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
            dvsr_reg   <= dvsr_next;
            sign_reg   <= sign_next;
            rsign_reg  <= rsign_next;
            dz_reg     <= dz_next;
            is_div_reg <= is_div_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign stall    = md_valid && busy;
    assign done     = done_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign md_rdata = (md_op == 3'b110) ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: multiply/divide results, latency, stall, MT/MF, flush and reset.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [31:0] md_rdata;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MDU_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .md_rdata (md_rdata),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        step();
        md_valid = 1'b0;
        #1;
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (!done && cyc < 200) begin
            if (busy) bc++;
            step();
            cyc++;
        end
    endtask

    // Expected accept-to-done edge count for a multiply, given the multiplier magnitude.
    function automatic int mul_lat(input logic [31:0] m);
        int k;
        if (!ET) return 33;
        k = 1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return k + 1;
    endfunction

    int  cyc;
    int  bc;
    bit  flag;

    initial begin
        reset    = 1'b1;
        md_valid = 1'b0;
        md_op    = 3'b000;
        rs_val   = '0;
        rt_val   = '0;
        flush    = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall, 0);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bc);
        $display("MULTU ffffffff*ffffffff hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("multu_max_lat", cyc, 33);
        chk("multu_max_busy", bc, 33);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);
        step();
        chk("multu_done_pulse", done, 0);

        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bc);
        $display("MULT -3*7 hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("mult_neg_lat", cyc, mul_lat(32'd7));
        chk("mult_neg_busy", bc, mul_lat(32'd7));
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bc);
        $display("DIV -7/2 hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("div_neg_lat", cyc, 33);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(3'b011, 32'd100, 32'd0);
        wait_done(cyc, bc);
        $display("DIVU 100/0 hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("divu_zero_lat", cyc, 33);
        chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
        chk("divu_zero_hi", hi, 32'd100);

        issue(3'b010, 32'hFFFF_FFF9, 32'd0);
        wait_done(cyc, bc);
        $display("DIV -7/0 hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("div_zero_lo", lo, 32'hFFFF_FFFF);
        chk("div_zero_hi", hi, 32'd7);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bc);
        $display("DIV 80000000/-1 hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        // MFLO held by the pipeline behind a multiply.
        issue(3'b001, 32'd6, 32'd7);
        md_valid = 1'b1;
        md_op    = 3'b111;
        #1;
        flag = 1'b1;
        cyc  = 0;
        while (!done && cyc < 200) begin
            if (stall !== 1'b1) flag = 1'b0;
            step();
            cyc++;
        end
        $display("MULTU 6*7 + MFLO rdata=%h cycles=%0d", md_rdata, cyc);
        chk("mflo_stall_busy", flag, 1);
        chk("mflo_lat", cyc, mul_lat(32'd7));
        chk("mflo_stall_done", stall, 0);
        chk("mflo_rdata", md_rdata, 32'd42);
        md_op = 3'b110;
        #1;
        chk("mfhi_rdata", md_rdata, 32'd0);
        md_valid = 1'b0;

        // MTHI held behind a multiply; hi goes 0 -> product hi -> MT data.
        issue(3'b001, 32'h0001_0000, 32'h0003_0000);
        md_valid = 1'b1;
        md_op    = 3'b100;
        rs_val   = 32'h0000_1234;
        #1;
        flag = 1'b1;
        cyc  = 0;
        while (!done && cyc < 200) begin
            if (stall !== 1'b1 || hi !== 32'd0) flag = 1'b0;
            step();
            cyc++;
        end
        $display("MULTU 10000*30000 + MTHI hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("mthi_held", flag, 1);
        chk("mthi_lat", cyc, mul_lat(32'h0003_0000));
        chk("mthi_done_hi", hi, 32'd3);
        chk("mthi_done_lo", lo, 32'd0);
        step();
        md_valid = 1'b0;
        #1;
        $display("MTHI 1234 hi=%h", hi);
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_busy", busy, 0);
        chk("mthi_no_done", done, 0);

        // Flush during a divide.
        issue(3'b011, 32'd1000, 32'd7);
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        $display("DIVU 1000/7 flushed hi=%h lo=%h", hi, lo);
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_hi", hi, 32'h0000_1234);
        chk("flush_lo", lo, 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) flag = 1'b1;
            step();
        end
        chk("flush_never_done", flag, 0);

        md_valid = 1'b1;
        md_op    = 3'b101;
        rs_val   = 32'h0000_DEAD;
        flush    = 1'b1;
        step();
        md_valid = 1'b0;
        flush    = 1'b0;
        #1;
        $display("MTLO dead with flush lo=%h", lo);
        chk("flush_mtlo_lo", lo, 32'd0);

        md_valid = 1'b1;
        md_op    = 3'b101;
        rs_val   = 32'h0000_BEEF;
        step();
        md_valid = 1'b0;
        #1;
        $display("MTLO beef lo=%h", lo);
        chk("mtlo_lo", lo, 32'h0000_BEEF);
        chk("mtlo_busy", busy, 0);

        // Reset in the middle of a multiply.
        issue(3'b000, 32'd5, 32'd5);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        $display("reset during MULT hi=%h lo=%h busy=%0d", hi, lo, busy);
        chk("rst_mul_hi", hi, 0);
        chk("rst_mul_lo", lo, 0);
        chk("rst_mul_busy", busy, 0);
        chk("rst_mul_done", done, 0);
        chk("rst_mul_stall", stall, 0);

        issue(3'b000, 32'd5, 32'hFFFF_FFFB);
        wait_done(cyc, bc);
        $display("MULT 5*-5 hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        chk("mult_post_rst_lat", cyc, mul_lat(32'd5));
        chk("mult_post_rst_hi", hi, 32'hFFFF_FFFF);
        chk("mult_post_rst_lo", lo, 32'hFFFF_FFE7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
